// File: rtl/addsub_flag_stage.sv
// Result stage behind the adder/subtractor: buffers results with Z/N/V/C flags, plus a sticky overflow bit.
// Latency: an entry accepted into an empty buffer is visible on out_* the following cycle.
// Backpressure: in_ready = (count < DEPTH) from registered state only; when full a push is refused even alongside a pop.
//
// Ports: clk/nrst (async active-low); in_valid/in_ready with a, b, sel (0=add, 1=sub), s (adder sum);
//        out_valid/out_ready with out_result, out_zero, out_neg, out_ovf, out_carry;
//        ovf_clr (sync clear) and ovf_sticky.
// Optional macro ADDSUB_SATURATE_EN: stored result saturates on signed overflow.
module addsub_flag_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic [WIDTH-1:0] s,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf,
    output logic             out_carry,
    input  logic             ovf_clr,
    output logic             ovf_sticky
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int EW    = WIDTH + 4;

    localparam logic [PTR_W-1:0] PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    // Entry layout: {ovf, carry, neg, zero, result}
    logic [EW-1:0]    mem_q [DEPTH];
    logic [EW-1:0]    mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_sticky_q, ovf_sticky_d;

    logic             push, pop;
    logic             ovf_new, carry_new;
    logic [WIDTH-1:0] res_new;
    logic [EW-1:0]    entry_new;
    logic [EW-1:0]    head;

    assign in_ready  = (count_q < CNT_MAX);
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Flag derivation at accept time; s is trusted as the adder result.
    always_comb begin
        ovf_new   = 1'b0;
        carry_new = 1'b0;
        res_new   = s;
        if (sel) begin
            ovf_new   = (a[WIDTH-1] != b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
            carry_new = (a >= b);
        end else begin
            ovf_new   = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
            // a + b carries out exactly when a > (2^W - 1 - b), i.e. a > ~b.
            carry_new = (a > ~b);
        end
`ifdef ADDSUB_SATURATE_EN
        // Clamp toward the sign of a: positive overflow -> max, negative -> min.
        if (ovf_new) begin
            res_new = {a[WIDTH-1], {(WIDTH-1){~a[WIDTH-1]}}};
        end
`endif
        entry_new = {ovf_new, carry_new, res_new[WIDTH-1], (res_new == '0), res_new};
    end

    always_comb begin
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        ovf_sticky_d = ovf_sticky_q;

        if (push) begin
            mem_d[wr_ptr_q] = entry_new;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end

        // A new overflow beats a simultaneous clear.
        if (push && ovf_new) begin
            ovf_sticky_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_sticky_q <= 1'b0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    // Outputs come only from the head entry and read as zero while empty.
    assign head       = out_valid ? mem_q[rd_ptr_q] : '0;
    assign out_result = head[WIDTH-1:0];
    assign out_zero   = head[WIDTH];
    assign out_neg    = head[WIDTH+1];
    assign out_carry  = head[WIDTH+2];
    assign out_ovf    = head[WIDTH+3];
    assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_addsub_flag_stage.sv
module tb_addsub_flag_stage;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             nrst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a, b, s;
    logic             sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_zero, out_neg, out_ovf, out_carry;
    logic             ovf_clr;
    logic             ovf_sticky;

    addsub_flag_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .sel        (sel),
        .s          (s),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .out_ovf    (out_ovf),
        .out_carry  (out_carry),
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] r;
        logic        z;
        logic        n;
        logic        o;
        logic        c;
    } ent_t;

    ent_t q[$];
    logic m_sticky;
    int   compared   = 0;
    int   mismatched = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Raw adder output as the upstream adder would produce it.
    function automatic logic [31:0] adder(input logic [31:0] x, input logic [31:0] y, input logic op);
        return op ? (x - y) : (x + y);
    endfunction

    // Reference: true signed/unsigned arithmetic in 64 bits, then range checks.
    function automatic ent_t ref_op(input logic [31:0] x, input logic [31:0] y, input logic op);
        ent_t   e;
        longint sx, sy, sr, ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        sr = op ? (sx - sy) : (sx + sy);
        e.o = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        e.c = op ? (ux >= uy) : ((ux + uy) >= 64'sh1_0000_0000);
        e.r = adder(x, y, op);
`ifdef ADDSUB_SATURATE_EN
        if (e.o) e.r = (sx < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        e.z = (e.r == 32'd0);
        e.n = e.r[31];
        return e;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'(($urandom_range(0, 15)));
            default: return $urandom;
        endcase
    endfunction

    // One clock: drive at negedge, check outputs against the model, advance model, wait for posedge.
    task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic isel, input logic ordy, input logic clr);
        ent_t head, e;
        logic do_push, do_pop;
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        sel       = isel;
        s         = adder(ia, ib, isel);
        out_ready = ordy;
        ovf_clr   = clr;
        #1;
        head = (q.size() != 0) ? q[0] : '0;
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
        chk("out_result", out_result, head.r);
        chk("out_zero", 32'(out_zero), 32'(head.z));
        chk("out_neg", 32'(out_neg), 32'(head.n));
        chk("out_ovf", 32'(out_ovf), 32'(head.o));
        chk("out_carry", 32'(out_carry), 32'(head.c));
        do_push = iv && (q.size() < DEPTH);
        do_pop  = (q.size() != 0) && ordy;
        e = ref_op(ia, ib, isel);
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(e);
        if (do_push && e.o) m_sticky = 1'b1;
        else if (clr) m_sticky = 1'b0;
        @(posedge clk);
    endtask

    initial begin
        int pops;
        nrst = 1'b0; in_valid = 1'b0; a = '0; b = '0; sel = 1'b0; s = '0;
        out_ready = 1'b0; ovf_clr = 1'b0;
        m_sticky = 1'b0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", out_result, 32'd0);
        chk("rst_flags", {28'd0, out_zero, out_neg, out_ovf, out_carry}, 32'd0);
        chk("rst_sticky", 32'(ovf_sticky), 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

        // 1: simple add
        step(1, 32'd5, 32'd3, 0, 1, 0);
        #2;
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_result", out_result, 32'd8);
        chk("t1_flags", {28'd0, out_zero, out_neg, out_ovf, out_carry}, 32'd0);

        // 2: subtract to zero, then to -1
        step(1, 32'd3, 32'd3, 1, 1, 0);
        #2;
        chk("t2_zero", 32'(out_zero), 32'd1);
        chk("t2_carry", 32'(out_carry), 32'd1);
        step(1, 32'd2, 32'd3, 1, 1, 0);
        #2;
        chk("t2_result", out_result, 32'hFFFF_FFFF);
        chk("t2_neg_carry_ovf", {29'd0, out_neg, out_carry, out_ovf}, 32'b100);

        // 3: signed overflow, sticky set, then cleared
        step(1, 32'h7FFF_FFFF, 32'd1, 0, 1, 0);
        #2;
        chk("t3_ovf", 32'(out_ovf), 32'd1);
`ifdef ADDSUB_SATURATE_EN
        chk("t3_result", out_result, 32'h7FFF_FFFF);
        chk("t3_neg", 32'(out_neg), 32'd0);
`else
        chk("t3_result", out_result, 32'h8000_0000);
        chk("t3_neg", 32'(out_neg), 32'd1);
`endif
        step(0, 0, 0, 0, 1, 0);
        chk("t3_sticky", 32'(ovf_sticky), 32'd1);
        step(0, 0, 0, 0, 1, 1);
        #2 chk("t3_sticky_clr", 32'(ovf_sticky), 32'd0);

        // 4: fill, refused extra push, drain in order
        for (int i = 0; i < DEPTH; i++) step(1, 32'(100 + i), 32'd1, 0, 0, 0);
        #2 chk("t4_full", 32'(in_ready), 32'd0);
        step(1, 32'd999, 32'd1, 0, 0, 0);
        for (int i = 0; i < DEPTH + 2; i++) step(0, 0, 0, 0, 1, 0);

        // 5: streaming, one result per cycle
        pops = 0;
        for (int i = 0; i < 16; i++) begin
            step(1, pick(), pick(), 1'($urandom_range(0, 1)), 1, 0);
            #2;
            chk("t5_in_ready", 32'(in_ready), 32'd1);
            if (out_valid) pops++;
        end
        chk("t5_count", 32'(pops), 32'd16);
        step(0, 0, 0, 0, 1, 0);

        // 6: reset with entries queued
        step(1, 32'h7FFF_FFFF, 32'd1, 0, 0, 0);
        step(1, 32'd5, 32'd6, 1, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 nrst = 1'b0;
        #1;
        chk("t6_valid", 32'(out_valid), 32'd0);
        chk("t6_sticky", 32'(ovf_sticky), 32'd0);
        chk("t6_result", out_result, 32'd0);
        q.delete();
        m_sticky = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0);

        // Random mix of traffic, backpressure and clears
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), pick(), pick(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
